lsu_ctrl: RTL and testbench

Multi-cycle load/store unit. It consumes the EXU's computed effective address (`result_o`) plus store data, and issues a valid/ready request to the data memory. It then returns aligned, sign- or zero-extended load data to writeback. It is the memory-side consumer of the EXU result, and the first block that lets the single-cycle core stall on memory.

---
 rtl/lsu_ctrl_pkg.sv | 31 +++
 rtl/lsu_load_align.sv | 28 ++
 rtl/lsu_ctrl.sv | 148 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule.
package lsu_ctrl_pkg;

    localparam int LSU_XLEN   = 32;
    localparam int LSU_MASK_W = LSU_XLEN / 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // The reserved size encoding 2'b11 is never aligned, so it is bounced as misaligned.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_B:  return 1'b1;
            SIZE_H:  return ~addr_lo[0];
            SIZE_W:  return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: selects the addressed byte/half/word from the raw
// memory word and sign- or zero-extends it.
module lsu_load_align
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN = LSU_XLEN
) (
    input  logic [XLEN-1:0] raw,
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = raw >> {addr_lo, 3'b000};
        case (size)
            SIZE_B:  data = is_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                        : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            SIZE_H:  data = is_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                        : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Multi-cycle load/store unit: accepts one access from the core, issues it to
// data memory over valid/ready and returns extended load data with a one-cycle pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a new access, req_ready_o high
// REQ     | mem_req_valid_o high, waiting for mem_req_ready_i
// WAIT    | request accepted by memory, waiting for mem_resp_valid_i
// RESP    | resp_valid_o pulse with rdata_o / misalign_o
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN   = LSU_XLEN,
    parameter int MASK_W = LSU_MASK_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   rdata_o,
    output logic              misalign_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic              mem_wen_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [MASK_W-1:0] mem_wmask_o,
    input  logic              mem_resp_valid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    lsu_state_e        state;
    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              wen_q;

    logic [MASK_W-1:0] lane_wmask;
    logic [XLEN-1:0]   lane_wdata;
    logic [XLEN-1:0]   load_data;
    logic              accept;

    assign accept = req_valid_i && (load_i || store_i);

    always_comb begin
        lane_wmask = {MASK_W{1'b1}};
        lane_wdata = wdata_i;
        case (size_i)
            SIZE_B: begin
                lane_wmask = MASK_W'(1) << addr_i[1:0];
                lane_wdata = {(XLEN/8){wdata_i[7:0]}};
            end
            SIZE_H: begin
                lane_wmask = MASK_W'(3) << addr_i[1:0];
                lane_wdata = {(XLEN/16){wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .raw         (mem_rdata_i),
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            addr_lo_q       <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            wen_q           <= 1'b0;
            req_ready_o     <= 1'b1;
            resp_valid_o    <= 1'b0;
            rdata_o         <= '0;
            misalign_o      <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_addr_o      <= '0;
            mem_wen_o       <= 1'b0;
            mem_wdata_o     <= '0;
            mem_wmask_o     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_lo_q   <= addr_i[1:0];
                        size_q      <= size_i;
                        uns_q       <= unsigned_i;
                        wen_q       <= store_i;
                        req_ready_o <= 1'b0;
                        if (is_aligned(size_i, addr_i[1:0])) begin
                            state           <= ST_REQ;
                            mem_req_valid_o <= 1'b1;
                            mem_addr_o      <= {addr_i[XLEN-1:2], 2'b00};
                            mem_wen_o       <= store_i;
                            mem_wdata_o     <= store_i ? lane_wdata : '0;
                            mem_wmask_o     <= store_i ? lane_wmask : '0;
                        end else begin
                            state        <= ST_RESP;
                            resp_valid_o <= 1'b1;
                            misalign_o   <= 1'b1;
                            rdata_o      <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready_i) begin
                        mem_req_valid_o <= 1'b0;
                        // Zero-latency memories answer in the handshake cycle.
                        if (mem_resp_valid_i) begin
                            state        <= ST_RESP;
                            resp_valid_o <= 1'b1;
                            rdata_o      <= wen_q ? '0 : load_data;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid_i) begin
                        state        <= ST_RESP;
                        resp_valid_o <= 1'b1;
                        rdata_o      <= wen_q ? '0 : load_data;
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_valid_o <= 1'b0;
                    misalign_o   <= 1'b0;
                    rdata_o      <= '0;
                    req_ready_o  <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan accesses, reset mid-transaction and
// randomized traffic checked against a byte-arithmetic reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        load_i;
    logic        store_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_rdata_i;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .load_i           (load_i),
        .store_i          (store_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .size_i           (size_i),
        .unsigned_i       (unsigned_i),
        .resp_valid_o     (resp_valid_o),
        .rdata_o          (rdata_o),
        .misalign_o       (misalign_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_wen_o        (mem_wen_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain byte arithmetic on the access description.
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    endfunction

    function automatic bit model_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (nbytes(sz) == 0) return 1'b0;
        return (a % nbytes(sz)) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [31:0] a,
                                               input logic [1:0] sz, input bit uns);
        int          bits;
        logic [31:0] v, m;
        bits = nbytes(sz) * 8;
        v = raw >> (8 * (a % 4));
        if (bits == 32) return v;
        m = (32'd1 << bits) - 32'd1;
        v = v & m;
        if (!uns && v[bits-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [3:0] model_mask(input logic [31:0] a, input logic [1:0] sz);
        int m;
        m = ((1 << nbytes(sz)) - 1) << (a % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
        if (nbytes(sz) == 1) return {24'd0, wd[7:0]} * 32'h01010101;
        if (nbytes(sz) == 2) return {16'd0, wd[15:0]} * 32'h00010001;
        return wd;
    endfunction

    // One complete access. Entered and left on a negedge; rdly = stall cycles
    // before mem_req_ready_i, sdly = cycles from ready to response.
    task automatic run(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit un, input int rdly, input int sdly,
                       input logic [31:0] raw, output logic [31:0] got_rdata,
                       output logic got_mis, output logic [3:0] got_mask,
                       output logic [31:0] got_wdata);
        int n;
        int rc;
        got_rdata = 'x;
        got_mis   = 'x;
        got_mask  = 'x;
        got_wdata = 'x;
        n = 0;
        while (!req_ready_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("idle_ready", req_ready_o, 1);
        req_valid_i = 1'b1;
        load_i      = ld;
        store_i     = st;
        addr_i      = a;
        wdata_i     = wd;
        size_i      = sz;
        unsigned_i  = un;
        @(negedge clk);
        req_valid_i = 1'b0;
        load_i      = 1'b0;
        store_i     = 1'b0;
        addr_i      = $urandom;
        wdata_i     = $urandom;
        if (!model_aligned(sz, a)) begin
            chk("mis_resp", resp_valid_o, 1);
            chk("mis_flag", misalign_o, 1);
            chk("mis_noreq", mem_req_valid_o, 0);
            chk("mis_rdata", rdata_o, 0);
            got_mis   = misalign_o;
            got_rdata = rdata_o;
            @(negedge clk);
            chk("mis_pulse_end", resp_valid_o, 0);
            chk("mis_noreq2", mem_req_valid_o, 0);
            chk("mis_back_idle", req_ready_o, 1);
        end else begin
            rc = 1 + rdly + sdly;
            for (int c = 1; c <= rc + 2; c++) begin
                mem_req_ready_i  = (c == 1 + rdly);
                mem_resp_valid_i = (c == rc);
                mem_rdata_i      = (c == rc) ? raw : $urandom;
                if (c <= 1 + rdly) begin
                    chk("req_valid", mem_req_valid_o, 1);
                    chk("req_addr", mem_addr_o, a & 32'hFFFF_FFFC);
                    chk("req_wen", mem_wen_o, st);
                    chk("req_wmask", mem_wmask_o, st ? model_mask(a, sz) : 4'b0000);
                    if (st) chk("req_wdata", mem_wdata_o, model_wdata(wd, sz));
                    if (c == 1) begin
                        got_mask  = mem_wmask_o;
                        got_wdata = mem_wdata_o;
                    end
                end else begin
                    chk("req_dropped", mem_req_valid_o, 0);
                end
                if (c <= rc) begin
                    chk("busy_not_ready", req_ready_o, 0);
                    chk("no_early_resp", resp_valid_o, 0);
                end
                if (c == rc + 1) begin
                    chk("resp_pulse", resp_valid_o, 1);
                    chk("resp_misalign", misalign_o, 0);
                    chk("resp_rdata", rdata_o, st ? 32'd0 : model_load(raw, a, sz, un));
                    got_rdata = rdata_o;
                    got_mis   = misalign_o;
                end
                if (c == rc + 2) begin
                    chk("resp_pulse_end", resp_valid_o, 0);
                    chk("resp_back_idle", req_ready_o, 1);
                end
                @(negedge clk);
            end
            mem_req_ready_i  = 1'b0;
            mem_resp_valid_i = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        mis;
        logic [3:0]  msk;
        logic [31:0] wdt;
        logic [31:0] ra;

        rst = 1'b1;
        req_valid_i = 1'b0;
        load_i = 1'b0;
        store_i = 1'b0;
        addr_i = '0;
        wdata_i = '0;
        size_i = '0;
        unsigned_i = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_rdata_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_resp_valid", resp_valid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_misalign", misalign_o, 0);
        chk("rst_mem_valid", mem_req_valid_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_mem_wen", mem_wen_o, 0);
        chk("rst_mem_wdata", mem_wdata_o, 0);
        chk("rst_mem_wmask", mem_wmask_o, 0);
        rst = 1'b0;
        @(negedge clk);

        run(1, 0, 32'h8000_0004, 32'h0, 2'd2, 0, 0, 0, 32'hDEAD_BEEF, rd, mis, msk, wdt);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_wmask", msk, 4'b0000);
        run(1, 0, 32'h8000_0003, 32'h0, 2'd0, 0, 0, 1, 32'h80FF_7F01, rd, mis, msk, wdt);
        chk("lb_rdata", rd, 32'hFFFF_FF80);
        run(1, 0, 32'h8000_0003, 32'h0, 2'd0, 1, 1, 0, 32'h80FF_7F01, rd, mis, msk, wdt);
        chk("lbu_rdata", rd, 32'h0000_0080);
        run(1, 0, 32'h8000_0002, 32'h0, 2'd1, 0, 0, 0, 32'h80FF_7F01, rd, mis, msk, wdt);
        chk("lh_rdata", rd, 32'hFFFF_80FF);
        run(0, 1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 0, 0, 0, 32'h1234_5678, rd, mis, msk, wdt);
        chk("sb_wmask", msk, 4'b0010);
        chk("sb_wdata", wdt, 32'hABAB_ABAB);
        chk("sb_rdata", rd, 32'h0);
        run(0, 1, 32'h8000_0002, 32'h0000_CAFE, 2'd1, 0, 0, 1, 32'h0, rd, mis, msk, wdt);
        chk("sh_wmask", msk, 4'b1100);
        chk("sh_wdata", wdt, 32'hCAFE_CAFE);
        run(0, 1, 32'h8000_0002, 32'h1111_2222, 2'd2, 0, 0, 0, 32'h0, rd, mis, msk, wdt);
        chk("sw_misalign", mis, 1);
        run(1, 0, 32'h8000_0001, 32'h0, 2'd1, 0, 0, 0, 32'h0, rd, mis, msk, wdt);
        chk("lh_misalign", mis, 1);
        run(1, 0, 32'h8000_0000, 32'h0, 2'd3, 0, 0, 0, 32'h0, rd, mis, msk, wdt);
        chk("size3_misalign", mis, 1);
        run(1, 0, 32'h8000_0008, 32'h0, 2'd2, 0, 3, 2, 32'h0BAD_F00D, rd, mis, msk, wdt);
        chk("bp_rdata", rd, 32'h0BAD_F00D);
        run(1, 1, 32'h8000_0000, 32'h5566_7788, 2'd2, 0, 1, 1, 32'hFFFF_FFFF, rd, mis, msk, wdt);
        chk("ld_st_store_wins", msk, 4'b1111);

        // Request with neither load nor store must be ignored.
        req_valid_i = 1'b1;
        addr_i = 32'h8000_0010;
        size_i = 2'd2;
        repeat (2) begin
            @(negedge clk);
            chk("nop_ready", req_ready_o, 1);
            chk("nop_no_req", mem_req_valid_o, 0);
            chk("nop_no_resp", resp_valid_o, 0);
        end
        req_valid_i = 1'b0;

        // Reset while waiting for the memory, then a stray response.
        req_valid_i = 1'b1;
        load_i = 1'b1;
        addr_i = 32'h8000_0020;
        size_i = 2'd2;
        @(negedge clk);
        req_valid_i = 1'b0;
        load_i = 1'b0;
        mem_req_ready_i = 1'b1;
        @(negedge clk);
        mem_req_ready_i = 1'b0;
        chk("wait_no_req", mem_req_valid_o, 0);
        chk("wait_not_ready", req_ready_o, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_ready", req_ready_o, 1);
        chk("rst_wait_no_resp", resp_valid_o, 0);
        mem_resp_valid_i = 1'b1;
        mem_rdata_i = 32'hAAAA_5555;
        @(negedge clk);
        mem_resp_valid_i = 1'b0;
        repeat (2) begin
            chk("stray_no_resp", resp_valid_o, 0);
            chk("stray_ready", req_ready_o, 1);
            chk("stray_no_req", mem_req_valid_o, 0);
            @(negedge clk);
        end
        run(1, 0, 32'h8000_0021, 32'h0, 2'd0, 1, 0, 1, 32'h0000_C300, rd, mis, msk, wdt);
        chk("post_rst_lbu", rd, 32'h0000_00C3);

        for (int i = 0; i < 60; i++) begin
            bit st;
            ra = {1'b1, 31'($urandom)};
            st = 1'($urandom_range(0, 1));
            run(~st, st, ra, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, rd, mis, msk, wdt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
